// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity selectors and frame length.
// Honours UART_TX_TWO_STOP_EN (two stop bits per frame when defined).
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

`ifdef UART_TX_TWO_STOP_EN
    localparam int unsigned STOP_BITS = 32'd2;
`else
    localparam int unsigned STOP_BITS = 32'd1;
`endif

    // Clock cycles per frame, first start-bit cycle to end of the last stop bit.
    function automatic int unsigned frame_cycles(input logic par_en, input int unsigned p);
        int unsigned pp;
        pp = (p == 32'd0) ? 32'd1 : p;
        return (32'd9 + STOP_BITS + (par_en ? 32'd1 : 32'd0)) * pp;
    endfunction

endpackage

// File: rtl/uart_tx_parity_calc.sv
// Combinational parity over the captured transmit byte; PAR_TYP selects even or odd.
module uart_tx_parity_calc
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  par_bit
);

    function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] d, input logic typ);
        return (typ == PAR_ODD) ? ~^d : ^d;
    endfunction

    assign par_bit = calc_parity(data, par_typ);

endmodule

// File: rtl/uart_tx_fsm.sv
// UART transmitter: start, DATA_WIDTH bits LSB first, optional parity, stop.
// Define UART_TX_TWO_STOP_EN to send two stop bits.
module uart_tx_fsm
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 5
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DATA_WIDTH-1:0]     P_DATA,
    input  logic                      Data_Valid,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      TX_OUT,
    output logic                      busy
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0]          LAST_BIT  = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0]          CNT_ONE   = CNT_W'(1);
    localparam logic [PRESCALE_WIDTH-1:0] PRESC_ONE = PRESCALE_WIDTH'(1);

    uart_state_e               state_r;
    logic [DATA_WIDTH-1:0]     data_r;
    logic                      par_en_r;
    logic                      par_typ_r;
    logic [PRESCALE_WIDTH-1:0] presc_r;
    logic [PRESCALE_WIDTH-1:0] edge_cnt_r;
    logic [CNT_W-1:0]          bit_cnt_r;
    logic [CNT_W-1:0]          next_bit_s;
    logic                      par_bit_s;
    logic                      bit_end_s;
`ifdef UART_TX_TWO_STOP_EN
    logic                      stop_half_r;
`endif

    uart_tx_parity_calc #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_parity (
        .data    (data_r),
        .par_typ (par_typ_r),
        .par_bit (par_bit_s)
    );

    // presc_r is never 0 outside IDLE, so P-1 cannot wrap while a bit is timed.
    assign bit_end_s  = (edge_cnt_r == (presc_r - PRESC_ONE));
    assign next_bit_s = bit_cnt_r + CNT_ONE;

    // Frame sequencer: captures the request, times each bit and drives the line.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r     <= IDLE;
            TX_OUT      <= 1'b1;
            busy        <= 1'b0;
            data_r      <= '0;
            par_en_r    <= 1'b0;
            par_typ_r   <= 1'b0;
            presc_r     <= '0;
            edge_cnt_r  <= '0;
            bit_cnt_r   <= '0;
`ifdef UART_TX_TWO_STOP_EN
            stop_half_r <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    TX_OUT <= 1'b1;
                    busy   <= 1'b0;
                    if (Data_Valid) begin
                        data_r     <= P_DATA;
                        par_en_r   <= PAR_EN;
                        par_typ_r  <= PAR_TYP;
                        presc_r    <= (prescale == '0) ? PRESC_ONE : prescale;
                        edge_cnt_r <= '0;
                        TX_OUT     <= 1'b0;
                        busy       <= 1'b1;
                        state_r    <= START;
                    end
                end
                START: begin
                    if (bit_end_s) begin
                        edge_cnt_r <= '0;
                        bit_cnt_r  <= '0;
                        TX_OUT     <= data_r[0];
                        state_r    <= DATA;
                    end else begin
                        edge_cnt_r <= edge_cnt_r + PRESC_ONE;
                    end
                end
                DATA: begin
                    if (bit_end_s) begin
                        edge_cnt_r <= '0;
                        if (bit_cnt_r == LAST_BIT) begin
                            if (par_en_r) begin
                                TX_OUT  <= par_bit_s;
                                state_r <= PARITY;
                            end else begin
                                TX_OUT  <= 1'b1;
                                state_r <= STOP;
                            end
                        end else begin
                            bit_cnt_r <= next_bit_s;
                            TX_OUT    <= data_r[next_bit_s];
                        end
                    end else begin
                        edge_cnt_r <= edge_cnt_r + PRESC_ONE;
                    end
                end
                PARITY: begin
                    if (bit_end_s) begin
                        edge_cnt_r <= '0;
                        TX_OUT     <= 1'b1;
                        state_r    <= STOP;
                    end else begin
                        edge_cnt_r <= edge_cnt_r + PRESC_ONE;
                    end
                end
                STOP: begin
                    TX_OUT <= 1'b1;
                    if (bit_end_s) begin
                        edge_cnt_r <= '0;
`ifdef UART_TX_TWO_STOP_EN
                        if (!stop_half_r) begin
                            stop_half_r <= 1'b1;
                        end else begin
                            stop_half_r <= 1'b0;
                            busy        <= 1'b0;
                            state_r     <= IDLE;
                        end
`else
                        busy    <= 1'b0;
                        state_r <= IDLE;
`endif
                    end else begin
                        edge_cnt_r <= edge_cnt_r + PRESC_ONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    TX_OUT  <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Self-checking bench for uart_tx_fsm: per-cycle expected {TX_OUT, busy} scoreboard.
module tb_uart_tx_fsm;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [4:0] prescale;
    logic       TX_OUT;
    logic       busy;

    int vectors     = 0;
    int miscompares = 0;
    logic [1:0] exp_q[$];

    always #5 CLK = ~CLK;

    uart_tx_fsm #(
        .DATA_WIDTH(8),
        .PRESCALE_WIDTH(5)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .prescale   (prescale),
        .TX_OUT     (TX_OUT),
        .busy       (busy)
    );

    // Expected line/busy per cycle for one frame, followed by one idle cycle.
    task automatic push_frame(input logic [7:0] d, input logic pe, input logic pt, input int p);
        int pp;
        int stop_bits;
        pp = (p == 0) ? 1 : p;
        stop_bits = 1;
`ifdef UART_TX_TWO_STOP_EN
        stop_bits = 2;
`endif
        repeat (pp) exp_q.push_back(2'b01);
        for (int i = 0; i < 8; i++) repeat (pp) exp_q.push_back({d[i], 1'b1});
        if (pe) repeat (pp) exp_q.push_back({(pt ? ~^d : ^d), 1'b1});
        repeat (pp * stop_bits) exp_q.push_back(2'b11);
        exp_q.push_back(2'b10);
    endtask

    task automatic start_req(input logic [7:0] d, input logic pe, input logic pt, input logic [4:0] p);
        @(negedge CLK);
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        prescale   = p;
        Data_Valid = 1'b1;
    endtask

    task automatic test_reset();
        RST = 1'b0; Data_Valid = 1'b0; P_DATA = 8'h00; PAR_EN = 1'b0; PAR_TYP = 1'b0; prescale = 5'd8;
        repeat (3) @(negedge CLK);
        vectors++;
        if ({TX_OUT, busy} !== 2'b10) begin
            miscompares++;
            $display("FAIL reset: tx/busy=%b expected 10", {TX_OUT, busy});
        end
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        vectors++;
        if ({TX_OUT, busy} !== 2'b10) begin
            miscompares++;
            $display("FAIL idle_after_reset: tx/busy=%b expected 10", {TX_OUT, busy});
        end
    endtask

    task automatic test_basic();
        logic [1:0] e;
        int busy_cnt = 0;
        int idx = 0;
        int exp_len = 80;
`ifdef UART_TX_TWO_STOP_EN
        exp_len = 88;
`endif
        start_req(8'hA5, 1'b0, 1'b0, 5'd8);
        push_frame(8'hA5, 1'b0, 1'b0, 8);
        while (exp_q.size() > 0) begin
            @(negedge CLK);
            Data_Valid = 1'b0;
            e = exp_q.pop_front();
            vectors++;
            if ({TX_OUT, busy} !== e) begin
                miscompares++;
                $display("FAIL basic_a5 cyc %0d: tx/busy=%b expected %b", idx, {TX_OUT, busy}, e);
            end
            if (busy) busy_cnt++;
            idx++;
        end
        vectors++;
        if (busy_cnt !== exp_len) begin
            miscompares++;
            $display("FAIL basic_busy_len: %0d expected %0d", busy_cnt, exp_len);
        end
    endtask

    task automatic test_parity();
        logic [1:0] e;
        int busy_cnt;
        int idx;
        int exp_len;
        for (int pt = 0; pt < 2; pt++) begin
            busy_cnt = 0; idx = 0; exp_len = 176;
`ifdef UART_TX_TWO_STOP_EN
            exp_len = 192;
`endif
            start_req(8'h07, 1'b1, pt[0], 5'd16);
            push_frame(8'h07, 1'b1, pt[0], 16);
            while (exp_q.size() > 0) begin
                @(negedge CLK);
                Data_Valid = 1'b0;
                e = exp_q.pop_front();
                vectors++;
                if ({TX_OUT, busy} !== e) begin
                    miscompares++;
                    $display("FAIL parity_typ%0d cyc %0d: tx/busy=%b expected %b", pt, idx, {TX_OUT, busy}, e);
                end
                if (idx == 9 * 16 + 5) begin
                    vectors++;
                    if (TX_OUT !== (pt == 0)) begin
                        miscompares++;
                        $display("FAIL parity_bit_typ%0d: %b expected %b", pt, TX_OUT, (pt == 0));
                    end
                end
                if (busy) busy_cnt++;
                idx++;
            end
            vectors++;
            if (busy_cnt !== exp_len) begin
                miscompares++;
                $display("FAIL parity_len_typ%0d: %0d expected %0d", pt, busy_cnt, exp_len);
            end
        end
    endtask

    task automatic test_midframe_ignore();
        logic [1:0] e;
        int idx = 0;
        start_req(8'h55, 1'b0, 1'b0, 5'd4);
        push_frame(8'h55, 1'b0, 1'b0, 4);
        repeat (6) exp_q.push_back(2'b10);
        while (exp_q.size() > 0) begin
            @(negedge CLK);
            e = exp_q.pop_front();
            vectors++;
            if ({TX_OUT, busy} !== e) begin
                miscompares++;
                $display("FAIL midframe cyc %0d: tx/busy=%b expected %b", idx, {TX_OUT, busy}, e);
            end
            Data_Valid = (idx == 10);
            if (idx == 10) begin
                P_DATA = 8'h3C; PAR_EN = 1'b1; PAR_TYP = 1'b1; prescale = 5'd2;
            end
            idx++;
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] e;
        int idx = 0;
        start_req(8'hC3, 1'b0, 1'b0, 5'd4);
        push_frame(8'hC3, 1'b0, 1'b0, 4);
        push_frame(8'hC3, 1'b0, 1'b0, 4);
        while (exp_q.size() > 0) begin
            @(negedge CLK);
            e = exp_q.pop_front();
            vectors++;
            if ({TX_OUT, busy} !== e) begin
                miscompares++;
                $display("FAIL back_to_back cyc %0d: tx/busy=%b expected %b", idx, {TX_OUT, busy}, e);
            end
            Data_Valid = (idx < 50);
            idx++;
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] e;
        int idx = 0;
        start_req(8'h5A, 1'b0, 1'b0, 5'd4);
        push_frame(8'h5A, 1'b0, 1'b0, 4);
        while (idx <= 17) begin
            @(negedge CLK);
            Data_Valid = 1'b0;
            e = exp_q.pop_front();
            vectors++;
            if ({TX_OUT, busy} !== e) begin
                miscompares++;
                $display("FAIL pre_reset cyc %0d: tx/busy=%b expected %b", idx, {TX_OUT, busy}, e);
            end
            idx++;
        end
        exp_q.delete();
        #2 RST = 1'b0;
        #1;
        vectors++;
        if ({TX_OUT, busy} !== 2'b10) begin
            miscompares++;
            $display("FAIL async_reset: tx/busy=%b expected 10", {TX_OUT, busy});
        end
        @(negedge CLK);
        RST = 1'b1;
        idx = 0;
        start_req(8'hFF, 1'b0, 1'b0, 5'd4);
        push_frame(8'hFF, 1'b0, 1'b0, 4);
        while (exp_q.size() > 0) begin
            @(negedge CLK);
            Data_Valid = 1'b0;
            e = exp_q.pop_front();
            vectors++;
            if ({TX_OUT, busy} !== e) begin
                miscompares++;
                $display("FAIL post_reset_ff cyc %0d: tx/busy=%b expected %b", idx, {TX_OUT, busy}, e);
            end
            idx++;
        end
    endtask

    task automatic test_prescale_zero();
        logic [1:0] e;
        int busy_cnt = 0;
        int idx = 0;
        int exp_len = 10;
`ifdef UART_TX_TWO_STOP_EN
        exp_len = 11;
`endif
        start_req(8'h81, 1'b0, 1'b0, 5'd0);
        push_frame(8'h81, 1'b0, 1'b0, 0);
        while (exp_q.size() > 0) begin
            @(negedge CLK);
            Data_Valid = 1'b0;
            e = exp_q.pop_front();
            vectors++;
            if ({TX_OUT, busy} !== e) begin
                miscompares++;
                $display("FAIL prescale0 cyc %0d: tx/busy=%b expected %b", idx, {TX_OUT, busy}, e);
            end
            if (busy) busy_cnt++;
            idx++;
        end
        vectors++;
        if (busy_cnt !== exp_len) begin
            miscompares++;
            $display("FAIL prescale0_len: %0d expected %0d", busy_cnt, exp_len);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_midframe_ignore();
        test_back_to_back();
        test_reset_mid();
        test_prescale_zero();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
